// File: rtl/apb_master.sv
// rtl/apb_master.sv - APB initiator: command stream in, single APB transfer out, response stream back.
module apb_master #(
  parameter int ADDR_W         = 12,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              pclk,
  input  logic              prst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              busy,
  output logic [ADDR_W-1:0] paddr,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  // A one-bit counter is kept when the timeout is disabled so widths stay legal.
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic             timeout_hit;

  assign cmd_ready   = (state == IDLE);
  assign busy        = (state != IDLE);
  assign timeout_hit = (TIMEOUT_CYCLES > 0) && (wait_cnt == CNT_LAST);

  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      paddr       <= '0;
      psel        <= 1'b0;
      penable     <= 1'b0;
      pwrite      <= 1'b0;
      pwdata      <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            paddr   <= cmd_addr;
            pwrite  <= cmd_write;
            pwdata  <= cmd_write ? cmd_wdata : '0;
            psel    <= 1'b1;
            penable <= 1'b0;
            state   <= SETUP;
          end
        end
        SETUP: begin
          penable  <= 1'b1;
          wait_cnt <= '0;
          state    <= ACCESS;
        end
        ACCESS: begin
          // pready is checked first so a completion on the last allowed cycle beats the abort.
          if (pready) begin
            rsp_rdata   <= pwrite ? '0 : prdata;
            rsp_err     <= pslverr;
            rsp_timeout <= 1'b0;
            rsp_valid   <= 1'b1;
            psel        <= 1'b0;
            penable     <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
            pwrite      <= 1'b0;
            state       <= RESP;
          end else if (timeout_hit) begin
            rsp_rdata   <= '0;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
            rsp_valid   <= 1'b1;
            psel        <= 1'b0;
            penable     <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
            pwrite      <= 1'b0;
            state       <= RESP;
          end else if (wait_cnt != '1) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// tb/tb_apb_master.sv - randomized directed bench for apb_master with a slave and outcome model.
module tb_apb_master;

  localparam int ADDR_W  = 12;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;

  logic              pclk = 1'b0;
  logic              prst_n = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic              cmd_write = 1'b0;
  logic [ADDR_W-1:0] cmd_addr = '0;
  logic [DATA_W-1:0] cmd_wdata = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;
  logic              busy;
  logic [ADDR_W-1:0] paddr;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata = '0;
  logic              pready = 1'b0;
  logic              pslverr = 1'b0;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  apb_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .pclk(pclk), .prst_n(prst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .busy(busy),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One full transfer. The slave answers after `waits` low-pready ACCESS cycles; the expected
  // outcome comes from the rule "more waits than the budget means timeout".
  task automatic do_txn(input logic wr, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata,
                        input int waits, input logic err, input logic [DATA_W-1:0] rdata,
                        input int bp, input logic hold_cmd);
    int n;
    logic to_exp;
    logic [DATA_W-1:0] exp_rd, exp_wd;
    to_exp = (TIMEOUT > 0) && (waits >= TIMEOUT);
    exp_rd = to_exp ? '0 : (wr ? '0 : rdata);
    exp_wd = wr ? wdata : '0;

    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
    check("idle_cmd_ready", cmd_ready, 1);
    check("idle_busy", busy, 0);
    @(posedge pclk); #1;
    cmd_valid = 1'b0; cmd_write = 1'($urandom_range(0, 1)); cmd_addr = ADDR_W'($urandom); cmd_wdata = $urandom;

    check("setup_psel", psel, 1);
    check("setup_penable", penable, 0);
    check("setup_paddr", paddr, addr);
    check("setup_pwrite", pwrite, wr);
    check("setup_pwdata", pwdata, exp_wd);
    check("setup_cmd_ready", cmd_ready, 0);
    check("setup_busy", busy, 1);
    @(posedge pclk); #1;

    n = 0;
    while (rsp_valid !== 1'b1 && n < 100) begin
      pready  = (n == waits);
      pslverr = (n == waits) ? err : 1'($urandom_range(0, 1));
      prdata  = (n == waits) ? rdata : $urandom;
      check("access_sel_en", {psel, penable}, 2'b11);
      check("access_paddr", paddr, addr);
      check("access_pwdata", pwdata, exp_wd);
      @(posedge pclk); #1;
      n++;
    end
    pready = 1'b0; pslverr = 1'b0; prdata = $urandom;

    check("access_len", n, to_exp ? TIMEOUT : waits + 1);
    check("rsp_valid", rsp_valid, 1);
    check("rsp_rdata", rsp_rdata, exp_rd);
    check("rsp_err", rsp_err, to_exp | err);
    check("rsp_timeout", rsp_timeout, to_exp);
    check("end_apb_idle", {psel, penable, pwrite}, 3'b000);
    check("end_paddr", paddr, 0);
    check("end_pwdata", pwdata, 0);

    for (int i = 0; i < bp; i++) begin
      if (hold_cmd) begin
        cmd_valid = 1'b1; cmd_write = 1'($urandom_range(0, 1)); cmd_addr = ADDR_W'($urandom);
      end
      @(posedge pclk); #1;
      check("bp_rsp_valid", rsp_valid, 1);
      check("bp_rsp_rdata", rsp_rdata, exp_rd);
      check("bp_rsp_flags", {rsp_err, rsp_timeout}, {to_exp | err, to_exp});
      check("bp_cmd_ready", cmd_ready, 0);
      check("bp_psel", psel, 0);
    end
    rsp_ready = 1'b1;
    @(posedge pclk); #1;
    rsp_ready = 1'b0;
    check("post_rsp_valid", rsp_valid, 0);
    check("post_cmd_ready", cmd_ready, 1);
    check("post_psel", psel, 0);
  endtask

  initial begin
    repeat (2) @(posedge pclk);
    #1;
    check("rst_apb", {psel, penable, pwrite}, 3'b000);
    check("rst_paddr", paddr, 0);
    check("rst_pwdata", pwdata, 0);
    check("rst_rsp", {rsp_valid, rsp_err, rsp_timeout}, 3'b000);
    check("rst_rdata", rsp_rdata, 0);
    @(negedge pclk);
    prst_n = 1'b1;
    @(posedge pclk); #1;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);

    do_txn(1'b1, 12'h004, 32'hA5A5_0001, 0, 1'b0, 32'h0, 0, 1'b0);
    do_txn(1'b0, 12'h010, 32'hDEAD_BEEF, 3, 1'b0, 32'h0000_00C3, 0, 1'b0);
    do_txn(1'b0, 12'hFFC, 32'h0, 0, 1'b1, 32'h1234_5678, 1, 1'b0);
    do_txn(1'b0, 12'h020, 32'h0, 1000, 1'b0, 32'h5555_AAAA, 0, 1'b0);
    do_txn(1'b1, 12'h024, 32'h0BAD_F00D, 1, 1'b0, 32'h0, 0, 1'b0);
    do_txn(1'b0, 12'h028, 32'h0, TIMEOUT - 1, 1'b0, 32'h7777_0001, 0, 1'b0);
    do_txn(1'b0, 12'h02C, 32'h0, TIMEOUT, 1'b1, 32'h7777_0002, 0, 1'b0);
    do_txn(1'b0, 12'h030, 32'h0, 2, 1'b0, 32'hCAFE_0030, 5, 1'b1);
    do_txn(1'b1, 12'h034, 32'h1111_2222, 0, 1'b0, 32'h0, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      int waits;
      waits = ($urandom_range(0, 7) == 0) ? int'($urandom_range(TIMEOUT - 2, TIMEOUT + 4))
                                          : int'($urandom_range(0, 4));
      do_txn(1'($urandom_range(0, 1)), ADDR_W'($urandom), $urandom, waits,
             1'($urandom_range(0, 1)), $urandom, int'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)));
    end

    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h040;
    @(posedge pclk); #1;
    cmd_valid = 1'b0;
    @(posedge pclk); #1;
    pready = 1'b0;
    repeat (3) @(posedge pclk);
    #3;
    prst_n = 1'b0;
    #1;
    check("mid_rst_sel_en", {psel, penable}, 2'b00);
    check("mid_rst_rsp_valid", rsp_valid, 0);
    check("mid_rst_busy", busy, 0);
    @(negedge pclk);
    prst_n = 1'b1;
    repeat (5) begin
      @(posedge pclk); #1;
      check("after_rst_rsp_valid", rsp_valid, 0);
      check("after_rst_cmd_ready", cmd_ready, 1);
      check("after_rst_psel", psel, 0);
    end
    do_txn(1'b1, 12'h044, 32'h600D_0044, 0, 1'b0, 32'h0, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
